// File: rtl/pc060ha_pkg.sv
// pc060ha_comm shared constants: page map and status bit positions.
// Optional feature macro: PC060HA_GPIO_EN (see pc060ha_comm.sv).
package pc060ha_pkg;

    localparam logic [2:0] PG_DATA0   = 3'd0;
    localparam logic [2:0] PG_DATA1   = 3'd1;
    localparam logic [2:0] PG_DATA2   = 3'd2;
    localparam logic [2:0] PG_DATA3   = 3'd3;
    localparam logic [2:0] PG_STATUS  = 3'd4;
    localparam logic [2:0] PG_GPIO    = 3'd5;
    localparam logic [2:0] PG_NMI_OFF = 3'd5;
    localparam logic [2:0] PG_NMI_ON  = 3'd6;
    localparam logic [2:0] PG_AMP     = 3'd7;

    localparam int ST_P01 = 0;
    localparam int ST_P23 = 1;
    localparam int ST_M01 = 2;
    localparam int ST_M23 = 3;

endpackage

// File: rtl/pc060ha_comm_if.sv
// Per-CPU bus bundle between the mailbox core and one pc060ha_port.
// The core drives strobes/read data; the port returns page, events and drive.
interface pc060ha_comm_if;
    logic       n_cs;
    logic       n_rd;
    logic       n_wr;
    logic       a0;
    logic [3:0] din;
    logic [3:0] rdata;
    logic [3:0] dout;
    logic [2:0] page;
    logic       rd_ev;
    logic       wr_ev;
    logic       oe;

    modport master (
        output n_cs, n_rd, n_wr, a0, din, rdata,
        input  page, rd_ev, wr_ev, oe, dout
    );

    modport slave (
        input  n_cs, n_rd, n_wr, a0, din, rdata,
        output page, rd_ev, wr_ev, oe, dout
    );
endinterface

// File: rtl/pc060ha_comm_port.sv
// One CPU port: strobe edge detect, auto-incrementing page register,
// and data-bus drive enable.
module pc060ha_port
    import pc060ha_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst,
    pc060ha_comm_if.slave  bus
);

    logic       r_rd_q;
    logic       r_wr_q;
    logic [2:0] r_page;
    logic       w_rd_stb;
    logic       w_wr_stb;

    assign w_rd_stb = ~bus.n_cs & ~bus.n_rd & r_rd_q;
    assign w_wr_stb = ~bus.n_cs & ~bus.n_wr & r_wr_q;

    assign bus.rd_ev = w_rd_stb & bus.a0;
    assign bus.wr_ev = w_wr_stb & bus.a0;
    assign bus.page  = r_page;
    assign bus.oe    = ~bus.n_cs & ~bus.n_rd & bus.a0;
    assign bus.dout  = bus.rdata;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_q <= 1'b1;
            r_wr_q <= 1'b1;
            r_page <= PG_DATA0;
        end else begin
            r_rd_q <= bus.n_rd;
            r_wr_q <= bus.n_wr;
            // data accesses step the page after the access completes
            if (w_wr_stb && !bus.a0)
                r_page <= bus.din[2:0];
            else if (bus.rd_ev || bus.wr_ev)
                r_page <= r_page + 3'd1;
        end
    end

endmodule

// File: rtl/pc060ha_comm.sv
// PC060HA-style nibble mailbox between master and sound CPU.
// `define PC060HA_GPIO_EN enables IN0/IN1 readback and the AMP latch.
module pc060ha_comm
    import pc060ha_pkg::*;
(
    input  logic       CLK,
    input  logic       IC,
    output logic       nROUT,
    input  logic       nMCS,
    input  logic       nMRD,
    input  logic       nMWR,
    input  logic       MA0,
    inout  wire  [3:0] MD,
    input  logic       nSCS,
    input  logic       nSRD,
    input  logic       nSWR,
    input  logic       SA0,
    inout  wire  [3:0] SD,
    input  logic       IN0,
    input  logic       IN1,
    output logic       nNMI,
    output logic       AMP
);

    pc060ha_comm_if m_if ();
    pc060ha_comm_if s_if ();

    logic [3:0] r_m2s [4];
    logic [3:0] r_s2m [4];
    logic [3:0] r_status;
    logic       r_nmi_en;
    logic       r_rst_latch;
    logic       r_nnmi;
    logic [3:0] w_set;
    logic [3:0] w_clr;
    logic [3:0] w_gpio;

    assign m_if.n_cs = nMCS;
    assign m_if.n_rd = nMRD;
    assign m_if.n_wr = nMWR;
    assign m_if.a0   = MA0;
    assign m_if.din  = MD;
    assign s_if.n_cs = nSCS;
    assign s_if.n_rd = nSRD;
    assign s_if.n_wr = nSWR;
    assign s_if.a0   = SA0;
    assign s_if.din  = SD;

    assign MD = m_if.oe ? m_if.dout : 4'bzzzz;
    assign SD = s_if.oe ? s_if.dout : 4'bzzzz;

    pc060ha_port u_mport (.i_clk(CLK), .i_rst(IC), .bus(m_if.slave));
    pc060ha_port u_sport (.i_clk(CLK), .i_rst(IC), .bus(s_if.slave));

`ifdef PC060HA_GPIO_EN
    assign w_gpio = {2'b00, IN1, IN0};
`else
    logic w_unused_gpio;
    assign w_unused_gpio = IN0 ^ IN1;
    assign w_gpio = 4'd0;
`endif

    always_comb begin
        m_if.rdata = 4'd0;
        case (m_if.page)
            PG_DATA0, PG_DATA1,
            PG_DATA2, PG_DATA3: m_if.rdata = r_s2m[m_if.page[1:0]];
            PG_STATUS:          m_if.rdata = r_status;
            PG_GPIO:            m_if.rdata = w_gpio;
            default:            m_if.rdata = 4'd0;
        endcase
    end

    always_comb begin
        s_if.rdata = 4'd0;
        case (s_if.page)
            PG_DATA0, PG_DATA1,
            PG_DATA2, PG_DATA3: s_if.rdata = r_m2s[s_if.page[1:0]];
            PG_STATUS:          s_if.rdata = r_status;
            PG_GPIO:            s_if.rdata = w_gpio;
            default:            s_if.rdata = 4'd0;
        endcase
    end

    always_comb begin
        w_set = 4'd0;
        w_clr = 4'd0;
        w_set[ST_P01] = m_if.wr_ev && m_if.page == PG_DATA1;
        w_set[ST_P23] = m_if.wr_ev && m_if.page == PG_DATA3;
        w_set[ST_M01] = s_if.wr_ev && s_if.page == PG_DATA1;
        w_set[ST_M23] = s_if.wr_ev && s_if.page == PG_DATA3;
        w_clr[ST_P01] = s_if.rd_ev && s_if.page == PG_DATA1;
        w_clr[ST_P23] = s_if.rd_ev && s_if.page == PG_DATA3;
        w_clr[ST_M01] = m_if.rd_ev && m_if.page == PG_DATA1;
        w_clr[ST_M23] = m_if.rd_ev && m_if.page == PG_DATA3;
    end

    always_ff @(posedge CLK) begin
        if (IC) begin
            for (int i = 0; i < 4; i++) begin
                r_m2s[i] <= 4'd0;
                r_s2m[i] <= 4'd0;
            end
            r_status    <= 4'd0;
            r_nmi_en    <= 1'b0;
            r_rst_latch <= 1'b0;
            r_nnmi      <= 1'b1;
        end else begin
            if (m_if.wr_ev) begin
                if (m_if.page[2] == 1'b0)
                    r_m2s[m_if.page[1:0]] <= m_if.din;
                else if (m_if.page == PG_STATUS)
                    r_rst_latch <= m_if.din[0];
            end
            if (s_if.wr_ev) begin
                if (s_if.page[2] == 1'b0)
                    r_s2m[s_if.page[1:0]] <= s_if.din;
                else if (s_if.page == PG_NMI_OFF)
                    r_nmi_en <= 1'b0;
                else if (s_if.page == PG_NMI_ON)
                    r_nmi_en <= 1'b1;
            end
            // a set in the same cycle as a clear wins
            r_status <= (r_status & ~w_clr) | w_set;
            r_nnmi   <= ~(r_nmi_en & (r_status[ST_P01] | r_status[ST_P23]));
        end
    end

`ifdef PC060HA_GPIO_EN
    logic r_amp;
    always_ff @(posedge CLK) begin
        if (IC)
            r_amp <= 1'b0;
        else if (s_if.wr_ev && s_if.page == PG_AMP)
            r_amp <= s_if.din[0];
    end
    assign AMP = r_amp;
`else
    assign AMP = 1'b0;
`endif

    assign nNMI  = r_nnmi;
    assign nROUT = ~(IC | r_rst_latch);

endmodule

// File: tb/tb_pc060ha_comm.sv
// Directed-vector bench for pc060ha_comm.
// Expected values follow the master/slave page map by hand.
module tb_pc060ha_comm;

    logic CLK = 1'b0;
    logic IC = 1'b1;
    logic nMCS = 1'b1, nMRD = 1'b1, nMWR = 1'b1, MA0 = 1'b0;
    logic nSCS = 1'b1, nSRD = 1'b1, nSWR = 1'b1, SA0 = 1'b0;
    logic IN0 = 1'b0, IN1 = 1'b0;
    logic nROUT, nNMI, AMP;
    logic [3:0] m_drv = 4'd0, s_drv = 4'd0;
    logic       m_oe = 1'b0, s_oe = 1'b0;
    wire  [3:0] MD, SD;
    logic [3:0] q;
    int n_tests = 0;
    int n_fail = 0;

    assign MD = m_oe ? m_drv : 4'bzzzz;
    assign SD = s_oe ? s_drv : 4'bzzzz;

    always #5 CLK = ~CLK;

    pc060ha_comm dut (
        .CLK(CLK), .IC(IC), .nROUT(nROUT),
        .nMCS(nMCS), .nMRD(nMRD), .nMWR(nMWR), .MA0(MA0), .MD(MD),
        .nSCS(nSCS), .nSRD(nSRD), .nSWR(nSWR), .SA0(SA0), .SD(SD),
        .IN0(IN0), .IN1(IN1), .nNMI(nNMI), .AMP(AMP)
    );

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_acc(input bit slv, input bit rd, input bit a0,
                           input logic [3:0] d, input bit cs_n,
                           output logic [3:0] qo);
        @(negedge CLK);
        if (slv) begin
            nSCS = cs_n; SA0 = a0;
            if (rd) nSRD = 1'b0;
            else begin nSWR = 1'b0; s_drv = d; s_oe = 1'b1; end
        end else begin
            nMCS = cs_n; MA0 = a0;
            if (rd) nMRD = 1'b0;
            else begin nMWR = 1'b0; m_drv = d; m_oe = 1'b1; end
        end
        #2 qo = slv ? SD : MD;
        @(negedge CLK);
        nMCS = 1'b1; nMRD = 1'b1; nMWR = 1'b1; m_oe = 1'b0;
        nSCS = 1'b1; nSRD = 1'b1; nSWR = 1'b1; s_oe = 1'b0;
    endtask

    task automatic m_wr(input bit a0, input logic [3:0] d);
        logic [3:0] x;
        bus_acc(1'b0, 1'b0, a0, d, 1'b0, x);
    endtask

    task automatic s_wr(input bit a0, input logic [3:0] d);
        logic [3:0] x;
        bus_acc(1'b1, 1'b0, a0, d, 1'b0, x);
    endtask

    task automatic m_rd(output logic [3:0] d);
        bus_acc(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, d);
    endtask

    task automatic s_rd(output logic [3:0] d);
        bus_acc(1'b1, 1'b1, 1'b1, 4'd0, 1'b0, d);
    endtask

    initial begin
        logic [3:0] exp_gpio;
        logic       exp_amp;
`ifdef PC060HA_GPIO_EN
        exp_gpio = 4'b0001;
        exp_amp  = 1'b1;
`else
        exp_gpio = 4'b0000;
        exp_amp  = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        check("nrout_in_reset", nROUT, 0);
        IC = 1'b0;
        @(negedge CLK);
        check("nrout_after_rst", nROUT, 1);
        check("nnmi_after_rst", nNMI, 1);
        check("amp_after_rst", AMP, 0);

        // deselected accesses do nothing
        bus_acc(1'b0, 1'b0, 1'b0, 4'd3, 1'b1, q);
        bus_acc(1'b0, 1'b0, 1'b1, 4'd5, 1'b1, q);
        check("cs_mpage", dut.u_mport.r_page, 0);
        @(negedge CLK);
        nMCS = 1'b1; nMRD = 1'b0; MA0 = 1'b1;
        #2 check("cs_no_drive", dut.m_if.oe, 0);
        @(negedge CLK);
        nMRD = 1'b1;
        s_wr(0, 4'd4); s_rd(q);
        check("cs_status", q, 4'b0000);

        // master to slave, both pairs
        m_wr(0, 4'd1); m_wr(1, 4'd1);
        m_wr(0, 4'd3); m_wr(1, 4'd7);
        m_rd(q); check("m_status_0011", q, 4'b0011);
        s_wr(0, 4'd1); s_rd(q); check("s_rd_pg1", q, 4'd1);
        s_wr(0, 4'd3); s_rd(q); check("s_rd_pg3", q, 4'd7);
        s_rd(q); check("s_status_clr", q, 4'b0000);

        // NMI enable/disable
        m_wr(0, 4'd1); m_wr(1, 4'd2);
        m_wr(0, 4'd4); m_rd(q); check("m_status_p01", q, 4'b0001);
        s_wr(0, 4'd6); s_wr(1, 4'd1);
        check("nnmi_latency", nNMI, 1);
        @(negedge CLK);
        check("nnmi_low", nNMI, 0);
        s_wr(0, 4'd5); s_wr(1, 4'd0);
        @(negedge CLK);
        check("nnmi_high", nNMI, 1);
        s_wr(0, 4'd1); s_rd(q); check("s_rd_p01", q, 4'd2);

        // slave to master burst with auto-increment
        s_wr(0, 4'd0);
        s_wr(1, 4'h8); s_wr(1, 4'h9); s_wr(1, 4'hA); s_wr(1, 4'hB);
        m_wr(0, 4'd4); m_rd(q); check("m_status_1100", q, 4'b1100);
        m_wr(0, 4'd0);
        m_rd(q); check("m_burst0", q, 4'h8);
        m_rd(q); check("m_burst1", q, 4'h9);
        m_rd(q); check("m_burst2", q, 4'hA);
        m_rd(q); check("m_burst3", q, 4'hB);
        check("m_page_end", dut.u_mport.r_page, 4);
        m_rd(q); check("m_status_clr", q, 4'b0000);

        // slave reset latch
        m_wr(0, 4'd4); m_wr(1, 4'd1);
        check("nrout_latch_on", nROUT, 0);
        m_wr(0, 4'd4); m_wr(1, 4'd0);
        check("nrout_latch_off", nROUT, 1);

        // GPIO and AMP
        IN0 = 1'b1; IN1 = 1'b0;
        m_wr(0, 4'd5); m_rd(q); check("m_gpio", q, exp_gpio);
        s_wr(0, 4'd5); s_rd(q); check("s_gpio", q, exp_gpio);
        s_rd(q); check("s_pg6_zero", q, 4'd0);
        s_wr(0, 4'd7); s_wr(1, 4'd1);
        check("amp", AMP, exp_amp);

        // one-cycle reset mid-operation
        m_wr(0, 4'd1); m_wr(1, 4'd5);
        s_wr(0, 4'd6); s_wr(1, 4'd1);
        m_wr(0, 4'd4); m_wr(1, 4'd1);
        @(negedge CLK);
        check("pre_ic_nnmi", nNMI, 0);
        check("pre_ic_nrout", nROUT, 0);
        IC = 1'b1;
        @(negedge CLK);
        IC = 1'b0;
        #1;
        check("ic_nrout", nROUT, 1);
        check("ic_nnmi", nNMI, 1);
        check("ic_amp", AMP, 0);
        check("ic_mpage", dut.u_mport.r_page, 0);
        check("ic_spage", dut.u_sport.r_page, 0);
        s_wr(0, 4'd4); s_rd(q); check("ic_status", q, 4'b0000);
        s_wr(0, 4'd1); s_rd(q); check("ic_m2s1", q, 4'd0);
        @(negedge CLK);
        check("ic_nnmi_hold", nNMI, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pc060ha_comm.md
Name: pc060ha_comm

Overview:
- Nibble-wide mailbox between the main CPU (master) and the sound CPU (slave), in the style of the Taito PC060HA.
- Each side has:
  - a paged register window: A0=0 selects the page register, A0=1 accesses the data register;
  - page auto-increment on every data access.
- It also provides full/empty handshake flags, slave NMI generation, a slave reset output, and small GPIO.

Parameters:
- none

Ports:
- CLK    in   1  single system clock; all logic on its rising edge
- IC     in   1  reset, synchronous, active-high
- nROUT  out  1  slave CPU reset, active-low
- nMCS   in   1  master chip select, active-low
- nMRD   in   1  master read strobe, active-low
- nMWR   in   1  master write strobe, active-low
- MA0    in   1  master address: 0 = page register, 1 = data register
- MD     inout 4 master data bus
- nSCS   in   1  slave chip select, active-low
- nSRD   in   1  slave read strobe, active-low
- nSWR   in   1  slave write strobe, active-low
- SA0    in   1  slave address: 0 = page register, 1 = data register
- SD     inout 4 slave data bus
- IN0    in   1  general-purpose input
- IN1    in   1  general-purpose input
- nNMI   out  1  slave NMI, active-low
- AMP    out  1  amplifier-enable latch

Behaviour:
- Reset (IC=1): all state and outputs return to known values.
  - Cleared to 0: mpage, spage, m2s[0..3], s2m[0..3], status[3:0], nmi_en, rst_latch, AMP.
  - nROUT=0 while IC=1.
- Access decode, master side (slave side identical):
  - Write strobe event: nMCS=0, nMWR=0 this cycle, and nMWR was 1 the previous cycle. MD is sampled in that cycle.
  - Read event: nMCS=0, nMRD=0 this cycle, and nMRD was 1 the previous cycle. Side effects occur once per read event.
- Bus drive:
  - MD is driven only while nMCS=0, nMRD=0 and MA0=1; otherwise Z.
  - SD follows the same rule with nSCS, nSRD, SA0.
  - Read data is combinational from the current page. Page-register reads (A0=0) are not decoded and leave the bus Z.
  - Any access with CS=1 is ignored.
- Page register writes: A0=0 write loads the page (3 bits) from D[2:0].
- Data access: every A0=1 read or write increments the page by 1 mod 8 after the access.
- Status bits:
  - b0 = P01 (master→slave pair 0/1 full)
  - b1 = P23 (master→slave pair 2/3 full)
  - b2 = M01 (slave→master pair 0/1 full)
  - b3 = M23 (slave→master pair 2/3 full)
- Master data, by page:
  - Write 0–3: store m2s[page]. Page 1 sets P01; page 3 sets P23.
  - Write 4: rst_latch = D[0].
  - Write 5–7: ignored.
  - Read 0–3: return s2m[page]. Reading page 1 clears M01; reading page 3 clears M23.
  - Read 4: return status.
  - Read 5: return {2'b00, IN1, IN0}.
  - Read 6–7: return 0.
- Slave data, by page:
  - Write 0–3: store s2m[page]. Page 1 sets M01; page 3 sets M23.
  - Write 5: nmi_en=0.
  - Write 6: nmi_en=1.
  - Write 7: AMP = D[0].
  - Write 4: ignored.
  - Read 0–3: return m2s[page]. Reading page 1 clears P01; reading page 3 clears P23.
  - Read 4: return status.
  - Read 5: return {2'b00, IN1, IN0}.
  - Read 6–7: return 0.
- Simultaneous set and clear of the same flag in one cycle: set wins.
- nNMI = ~(nmi_en & (P01 | P23)), registered with one cycle of latency.
- nROUT = ~(IC | rst_latch).
- A reset pulse of a single cycle restores reset state; there is no glitch filtering.

Optional Feature:
- PC060HA_GPIO_EN
  - Defined: IN0/IN1 readable at page 5; slave page-7 writes control AMP.
  - Undefined: page 5 reads 0; page-7 writes ignored; AMP tied 0.

Decomposition:
- Package pc060ha_pkg holds:
  - page constants PG_DATA0..PG_DATA3, PG_STATUS=4, PG_GPIO=5, PG_NMI_OFF=5, PG_NMI_ON=6, PG_AMP=7;
  - status bit indices.
- Sub-module pc060ha_port: one CPU port, handling strobe edge detect, page register with auto-increment, and bus tristate control. It is instantiated twice, once for the master and once for the slave.

Test Plan:
- Master read/write with nMCS=1 → no state change; MD stays Z.
- Master writes page=1, data=1, then page=3, data=7 → status=4'b0011. Slave reads at page 1 → 1; slave reads at page 3 → 7; status then 0.
- Master writes P01 (status=0001), then slave writes page 6, data 1 → nNMI low one cycle later. Slave then writes page 5 → nNMI high.
- Slave writes page 0, then data 8,9,A,B → status b2,b3 set. Master page 0, then four reads → 8,9,A,B; status M01/M23 cleared; master page ends at 4.
- Master writes page 4, data 1 → nROUT=0. Master writes page 4, data 0 → nROUT=1.
- IC pulsed for one cycle mid-operation → all registers 0; nNMI=1; nROUT=1 after release.
